alarm_pattern_gen: RTL and testbench

- Parametrised successor to the fixed 5-beep alarm driver.
- Produces a registered beep/gap/pause pattern on a configurable-width output bus.
- Beep count and mode (repeat, continuous, one-shot) are selectable at run time; snooze is supported.
- Sits between the alarm-compare logic (drives `on`) and the buzzer/LED bank (consumes `cout`). Runs on the 1 kHz tick clock.

---
 rtl/alarm_pkg.sv | 54 +++++
 rtl/phase_timer.sv | 31 +++
 rtl/alarm_pattern_gen.sv | 143 ++++++++++++++
 tb/tb_alarm_pattern_gen.sv | 237 +++++++++++++++++++++++
 4 files changed

// File: rtl/alarm_pkg.sv
// Shared definitions for the alarm pattern generator and later clock blocks.
//   state_t  : pattern FSM states
//   mode_t   : run-time pattern modes (encoding 2'b11 folds onto repeat)
//   DEF_*    : default phase lengths in 1 kHz ticks
//   norm_mode / clamp_count : input conditioning applied when a pattern starts
package alarm_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_BEEP,
    ST_GAP,
    ST_PAUSE,
    ST_SNOOZE,
    ST_DONE
  } state_t;

  typedef enum logic [1:0] {
    MODE_REPEAT  = 2'b00,
    MODE_CONT    = 2'b01,
    MODE_ONESHOT = 2'b10
  } mode_t;

  localparam int DEF_OUT_W      = 8;
  localparam int DEF_CNT_W      = 16;
  localparam int DEF_BEEP_LEN   = 200;
  localparam int DEF_GAP_LEN    = 100;
  localparam int DEF_PAUSE_LEN  = 400;
  localparam int DEF_SNOOZE_LEN = 5000;
  localparam int DEF_MAX_BEEPS  = 8;

  // 2'b11 has no meaning of its own; it behaves as repeat.
  function automatic mode_t norm_mode(input logic [1:0] m);
    mode_t r;
    case (m)
      2'b01:   r = MODE_CONT;
      2'b10:   r = MODE_ONESHOT;
      default: r = MODE_REPEAT;
    endcase
    return r;
  endfunction

  // Zero beeps would make an empty pattern, so it becomes one beep.
  function automatic logic [3:0] clamp_count(input logic [3:0] bc, input int max_beeps);
    logic [3:0] r;
    if (bc == 4'd0)
      r = 4'd1;
    else if (int'(bc) > max_beeps)
      r = 4'(max_beeps);
    else
      r = bc;
    return r;
  endfunction

endpackage

// File: rtl/phase_timer.sv
// Loadable up-counter that times one FSM phase.
//   clk, rst : phase clock, async active-high reset
//   load     : restart counting from zero (phase entry)
//   hold     : freeze the count (untimed states)
//   len      : length of the current phase in cycles
//   count    : cycles elapsed in the current phase
//   tc       : last cycle of the phase (count == len-1)
module phase_timer #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic             hold,
  input  logic [CNT_W-1:0] len,
  output logic [CNT_W-1:0] count,
  output logic             tc
);

  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      count <= '0;
    else if (load)
      count <= '0;
    else if (!hold)
      count <= count + CNT_W'(1);
  end

  assign tc = (count == len - CNT_W'(1));

endmodule

// File: rtl/alarm_pattern_gen.sv
// Alarm beep pattern generator: beep/gap/pause sequencing with repeat,
// continuous and one-shot modes plus snooze, on the 1 kHz tick clock.
//   clk1khz    : tick clock, all state on rising edge
//   rst        : async active-high reset
//   on         : alarm enable level; low forces IDLE next edge
//   mode       : 00 repeat, 01 continuous, 10 one-shot, 11 as repeat
//   beep_count : beeps per pattern, 0 -> 1, clamped to MAX_BEEPS
//   snooze     : single-cycle snooze request (BEEP/GAP/PAUSE/SNOOZE)
//   cout       : all ones while beeping (registered)
//   active     : pattern running (BEEP/GAP/PAUSE)
//   done       : one-shot pattern finished
module alarm_pattern_gen
  import alarm_pkg::*;
#(
  parameter int OUT_W      = DEF_OUT_W,
  parameter int CNT_W      = DEF_CNT_W,
  parameter int BEEP_LEN   = DEF_BEEP_LEN,
  parameter int GAP_LEN    = DEF_GAP_LEN,
  parameter int PAUSE_LEN  = DEF_PAUSE_LEN,
  parameter int SNOOZE_LEN = DEF_SNOOZE_LEN,
  parameter int MAX_BEEPS  = DEF_MAX_BEEPS
) (
  input  logic             clk1khz,
  input  logic             rst,
  input  logic             on,
  input  logic [1:0]       mode,
  input  logic [3:0]       beep_count,
  input  logic             snooze,
  output logic [OUT_W-1:0] cout,
  output logic             active,
  output logic             done
);

  state_t           state, nxt;
  mode_t            mode_q;
  logic [3:0]       n_q;      // effective beeps per pattern, latched at start
  logic [3:0]       idx;      // beep index within the pattern
  logic [CNT_W-1:0] len;
  logic [CNT_W-1:0] count;
  logic             tc;
  logic             load;
  logic             hold;

  // Length of the phase currently being timed.
  always_comb begin
    len = CNT_W'(BEEP_LEN);
    case (state)
      ST_GAP:    len = CNT_W'(GAP_LEN);
      ST_PAUSE:  len = CNT_W'(PAUSE_LEN);
      ST_SNOOZE: len = CNT_W'(SNOOZE_LEN);
      default:   len = CNT_W'(BEEP_LEN);
    endcase
  end

  // Next state. `on` low wins over everything; snooze wins over phase ends.
  always_comb begin
    nxt = state;
    if (!on) begin
      nxt = ST_IDLE;
    end else begin
      case (state)
        ST_IDLE: nxt = ST_BEEP;
        ST_BEEP: begin
          if (snooze)
            nxt = ST_SNOOZE;
          else if (mode_q != MODE_CONT && tc)
            nxt = (idx < n_q - 4'd1) ? ST_GAP : ST_PAUSE;
        end
        ST_GAP: begin
          if (snooze)
            nxt = ST_SNOOZE;
          else if (tc)
            nxt = ST_BEEP;
        end
        ST_PAUSE: begin
          if (snooze)
            nxt = ST_SNOOZE;
          else if (tc)
            nxt = (mode_q == MODE_ONESHOT) ? ST_DONE : ST_BEEP;
        end
        ST_SNOOZE: begin
          // A fresh request restarts the silence instead of ending it.
          if (!snooze && tc)
            nxt = ST_BEEP;
        end
        ST_DONE: nxt = ST_DONE;
        default: nxt = ST_IDLE;
      endcase
    end
  end

  // Every state entry restarts the timer; so does a repeated snooze, which
  // is the one restart that does not change state.
  assign load = (nxt != state) || (state == ST_SNOOZE && on && snooze);

  // Continuous tone never ends its beep; IDLE and DONE are untimed.
  assign hold = (state == ST_BEEP && mode_q == MODE_CONT) ||
                (state == ST_IDLE) || (state == ST_DONE);

  phase_timer #(
    .CNT_W (CNT_W)
  ) u_timer (
    .clk   (clk1khz),
    .rst   (rst),
    .load  (load),
    .hold  (hold),
    .len   (len),
    .count (count),
    .tc    (tc)
  );

  // State, latched configuration and outputs. Outputs are decoded from the
  // next state so they change on the same edge as the state register.
  always_ff @(posedge clk1khz or posedge rst) begin
    if (rst) begin
      state  <= ST_IDLE;
      mode_q <= MODE_REPEAT;
      n_q    <= 4'd1;
      idx    <= 4'd0;
      cout   <= '0;
      active <= 1'b0;
      done   <= 1'b0;
    end else begin
      state  <= nxt;
      cout   <= {OUT_W{nxt == ST_BEEP}};
      active <= (nxt == ST_BEEP) || (nxt == ST_GAP) || (nxt == ST_PAUSE);
      done   <= (nxt == ST_DONE);

      if (state == ST_IDLE && on) begin
        mode_q <= norm_mode(mode);
        n_q    <= clamp_count(beep_count, MAX_BEEPS);
      end

      // A pattern begins at beep 0 from start, pause wrap or snooze end.
      if (nxt == ST_BEEP &&
          (state == ST_IDLE || state == ST_PAUSE || state == ST_SNOOZE))
        idx <= 4'd0;
      else if (state == ST_BEEP && nxt == ST_GAP)
        idx <= idx + 4'd1;
    end
  end

endmodule

// File: tb/tb_alarm_pattern_gen.sv
module tb_alarm_pattern_gen;

  localparam int B    = 4;
  localparam int G    = 2;
  localparam int PA   = 6;
  localparam int SL   = 10;
  localparam int MAXB = 8;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       on = 1'b0;
  logic [1:0] mode = 2'b00;
  logic [3:0] beep_count = 4'd0;
  logic       snooze = 1'b0;
  logic [7:0] cout;
  logic       active;
  logic       done;

  int total = 0;
  int bad   = 0;

  typedef struct packed {
    logic [7:0] c;
    logic       a;
    logic       d;
  } exp_t;
  exp_t exp_q[$];

  always #5 clk = ~clk;

  alarm_pattern_gen #(
    .OUT_W      (8),
    .CNT_W      (16),
    .BEEP_LEN   (B),
    .GAP_LEN    (G),
    .PAUSE_LEN  (PA),
    .SNOOZE_LEN (SL),
    .MAX_BEEPS  (MAXB)
  ) dut (
    .clk1khz    (clk),
    .rst        (rst),
    .on         (on),
    .mode       (mode),
    .beep_count (beep_count),
    .snooze     (snooze),
    .cout       (cout),
    .active     (active),
    .done       (done)
  );

  // Zero-length phases are not a legal configuration.
  initial begin
    assert (B > 0 && G > 0 && PA > 0 && SL > 0 && MAXB > 0)
      else $fatal(1, "illegal zero-length parameter");
  end

  // Reference model: time since pattern start, with the pattern shape
  // computed arithmetically from the period.
  localparam int R_IDLE = 0, R_RUN = 1, R_SNZ = 2, R_DONE = 3;
  int m_st = R_IDLE;
  int m_t  = 0;
  int m_s  = 0;
  int m_md = 0;   // 0 repeat, 1 continuous, 2 one-shot
  int m_n  = 1;

  function automatic int period(input int n);
    return n * B + (n - 1) * G + PA;
  endfunction

  function automatic bit beeping(input int tt, input int n);
    int pos, k, r;
    pos = tt % period(n);
    k   = pos / (B + G);
    r   = pos % (B + G);
    return (k < n) && (r < B);
  endfunction

  function automatic exp_t model_out();
    exp_t e;
    e = '0;
    case (m_st)
      R_RUN: begin
        e.c = (m_md == 1 || beeping(m_t, m_n)) ? 8'hFF : 8'h00;
        e.a = 1'b1;
      end
      R_DONE: e.d = 1'b1;
      default: e = '0;
    endcase
    return e;
  endfunction

  // Drive one cycle of inputs at the falling edge, advance the model across
  // the coming rising edge and queue what the DUT must show after it.
  task automatic step(input logic o, input logic [1:0] m, input logic [3:0] bc,
                      input logic sn);
    @(negedge clk);
    on = o; mode = m; beep_count = bc; snooze = sn;
    if (!o) begin
      m_st = R_IDLE;
    end else begin
      case (m_st)
        R_IDLE: begin
          m_md = (m == 2'b01) ? 1 : (m == 2'b10) ? 2 : 0;
          m_n  = (bc == 4'd0) ? 1 : (int'(bc) > MAXB) ? MAXB : int'(bc);
          m_t  = 0;
          m_st = R_RUN;
        end
        R_RUN: begin
          if (sn) begin
            m_st = R_SNZ;
            m_s  = 0;
          end else begin
            m_t++;
            if (m_md == 2 && m_t >= period(m_n)) m_st = R_DONE;
          end
        end
        R_SNZ: begin
          if (sn) m_s = 0;
          else if (m_s == SL - 1) begin
            m_st = R_RUN;
            m_t  = 0;
          end else m_s++;
        end
        default: ;
      endcase
    end
    exp_q.push_back(model_out());
  endtask

  task automatic run(input int cycles, input logic o, input logic [1:0] m,
                     input logic [3:0] bc);
    for (int i = 0; i < cycles; i++) step(o, m, bc, 1'b0);
  endtask

  task automatic chk(input string name, input logic [7:0] got, input logic [7:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, got, want);
    end
  endtask

  task automatic async_reset();
    @(posedge clk);
    #3 rst = 1'b1;
    #1;
    chk("rst_cout", cout, 8'h00);
    chk("rst_active", {7'd0, active}, 8'h00);
    chk("rst_done", {7'd0, done}, 8'h00);
    on = 1'b0; snooze = 1'b0;
    @(posedge clk);
    #2 rst = 1'b0;
    m_st = R_IDLE;
  endtask

  // Monitor: every rising edge with a queued expectation is compared.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        total++;
        if (cout !== e.c || active !== e.a || done !== e.d) begin
          bad++;
          $display("FAIL scoreboard @%0t: cout=%h want %h active=%b want %b done=%b want %b",
                   $time, cout, e.c, active, e.a, done, e.d);
        end
      end
    end
  end

  initial begin
    // Reset state
    @(posedge clk);
    #2;
    chk("init_cout", cout, 8'h00);
    chk("init_active", {7'd0, active}, 8'h00);
    chk("init_done", {7'd0, done}, 8'h00);
    @(posedge clk);
    #2 rst = 1'b0;

    // Repeat, n=3: two full 22-cycle patterns and a bit
    run(50, 1'b1, 2'b00, 4'd3);
    run(2, 1'b0, 2'b00, 4'd3);
    // Clamp low and high
    run(25, 1'b1, 2'b00, 4'd0);
    run(1, 1'b0, 2'b00, 4'd0);
    run(110, 1'b1, 2'b00, 4'd15);
    run(1, 1'b0, 2'b00, 4'd0);
    // Mode 11 behaves as repeat
    run(30, 1'b1, 2'b11, 4'd2);
    run(1, 1'b0, 2'b00, 4'd0);
    // One-shot n=2, drop on, restart
    run(25, 1'b1, 2'b10, 4'd2);
    run(2, 1'b0, 2'b10, 4'd2);
    run(30, 1'b1, 2'b10, 4'd2);
    run(1, 1'b0, 2'b00, 4'd0);
    // Continuous tone, then off
    run(110, 1'b1, 2'b01, 4'd3);
    run(2, 1'b0, 2'b01, 4'd3);
    // Snooze in second beep, re-snooze at snooze cycle 5
    run(7, 1'b1, 2'b00, 4'd3);
    step(1'b1, 2'b00, 4'd3, 1'b1);
    run(4, 1'b1, 2'b00, 4'd3);
    step(1'b1, 2'b00, 4'd3, 1'b1);
    run(30, 1'b1, 2'b00, 4'd3);
    // on low together with snooze
    step(1'b0, 2'b00, 4'd3, 1'b1);
    run(2, 1'b0, 2'b00, 4'd3);
    // Async reset mid-GAP, then IDLE until on is sampled high again
    run(5, 1'b1, 2'b00, 4'd3);
    async_reset();
    run(3, 1'b0, 2'b00, 4'd3);
    run(30, 1'b1, 2'b00, 4'd3);

    // Randomized operation
    for (int i = 0; i < 3000; i++) begin
      step(($urandom_range(0, 99) < 97) ? 1'b1 : 1'b0,
           2'($urandom_range(0, 3)),
           4'($urandom_range(0, 15)),
           ($urandom_range(0, 99) < 3) ? 1'b1 : 1'b0);
    end

    @(posedge clk);
    #3;
    total++;
    if (exp_q.size() != 0) begin
      bad++;
      $display("FAIL drain: %0d expectations left, want 0", exp_q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
